pfpu_if: RTL

- PFPU ALU unit that consumes the boolean-as-float values (1.0f = 0x3f800000, 0.0f = 0x00000000) produced by the comparison units.
- Selects between two float operands under that condition: r = cond ? a : b.
- Fixed-latency pipeline with a valid strobe, so it slots into the PFPU ALU result mux alongside the other units.
- Flags and counts condition operands that are not canonical booleans, for microcode debug.

---
 rtl/pfpu_if.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pfpu_if.sv
// ---------------------------------------------------------------------------
// pfpu_if - PFPU conditional-select ALU unit.
//
// Computes r = cond ? a : b, where cond is a float boolean produced by the
// comparison units (1.0f = 0x3f800000, +/-0.0f = false). Any operand with a
// nonzero magnitude counts as true. Conditions that are not one of the three
// canonical encodings are flagged per result and tallied in a saturating
// counter so microcode bugs can be spotted.
//
// Parameters
//   LATENCY  pipeline depth from valid_i to valid_o, 1..4
//   CNT_W    width of the saturating non-boolean counter
//
// Ports
//   sys_clk        system clock
//   sys_rst_n      asynchronous active-low reset
//   alu_rst        synchronous flush: drops every in-flight and incoming op
//   a, b           operands selected on true / false condition
//   c              condition operand (float boolean)
//   valid_i        operands valid this cycle
//   r              selected result, meaningful only while valid_o = 1
//   valid_o        result valid this cycle
//   nonbool_o      result in flight had a non-canonical condition
//   nonbool_count  saturating count of non-canonical results
//   count_clr      synchronous clear of nonbool_count (wins over increment)
// ---------------------------------------------------------------------------
module pfpu_if #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             alu_rst,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      c,
    input  logic             valid_i,
    output logic [31:0]      r,
    output logic             valid_o,
    output logic             nonbool_o,
    output logic [CNT_W-1:0] nonbool_count,
    input  logic             count_clr
);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("pfpu_if: LATENCY must be in 1..4");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Sign bit ignored so that -0.0 decodes as false like +0.0.
    function automatic logic cond_true(input logic [31:0] v);
        return (v[30:0] != 31'd0);
    endfunction

    function automatic logic cond_canonical(input logic [31:0] v);
        return (v == 32'h0000_0000) || (v == 32'h8000_0000) ||
               (v == 32'h3f80_0000);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [31:0]        data_p [LATENCY];
    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] nb_p;

    // ---- stage 1: select and decode; stages 2..LATENCY: plain delay ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_p[i] <= '0;
            end
        end else begin
            data_p[0] <= cond_true(c) ? a : b;
            for (int i = 1; i < LATENCY; i++) begin
                data_p[i] <= data_p[i-1];
            end
        end
    end

    // Flush clears valid/nonbool only; data keeps shifting since r is
    // qualified by valid_o anyway.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p <= '0;
            nb_p  <= '0;
        end else if (alu_rst) begin
            vld_p <= '0;
            nb_p  <= '0;
        end else begin
            vld_p[0] <= valid_i;
            nb_p[0]  <= valid_i & ~cond_canonical(c);
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                nb_p[i]  <= nb_p[i-1];
            end
        end
    end

    // ---- output stage ----
    assign r         = data_p[LATENCY-1];
    assign valid_o   = vld_p[LATENCY-1];
    // nb bits are only ever set together with their valid bit; the AND keeps
    // nonbool_o quiet regardless.
    assign nonbool_o = nb_p[LATENCY-1] & vld_p[LATENCY-1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            nonbool_count <= '0;
        end else if (count_clr) begin
            nonbool_count <= '0;
        end else if (valid_o && nonbool_o) begin
            nonbool_count <= sat_inc(nonbool_count);
        end
    end

endmodule
